// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the opcode decoder.
package fetch_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_LWI   = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_BLT   = 6'b000011;
  localparam logic [5:0] OP_BGE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [31:0] NOP_INSTR = 32'hFC000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC selection: jump target, taken-branch offset or sequential increment.
module next_pc_sel #(
  parameter int unsigned PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  logic            jump,
  input  logic            branch,
  input  logic            branch_flip,
  input  logic            alu_zero,
  output logic            taken,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_inc;

  // Branch resolution and PC priority mux; jump overrides any branch.
  always_comb begin
    pc_inc  = pc + PC_W'(1);
    taken   = branch & (alu_zero ^ branch_flip);
    next_pc = pc_inc;
    if (jump) begin
      next_pc = imm;
    end else if (taken) begin
      next_pc = pc_inc + imm;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: holds the PC, fetches instruction words and issues them to decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  fetch_sequencer_if.master  imem,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               branch_flip,
  input  logic               alu_zero,
  output logic [PC_W-1:0]    pc,
  output logic               redirect,
  output logic [15:0]        retired
);

  state_t          state, state_next;
  logic            req;
  logic            fetch_done;
  logic            retire;
  logic            taken;
  logic [PC_W-1:0] next_pc;

  next_pc_sel #(
    .PC_W(PC_W)
  ) u_next_pc_sel (
    .pc         (pc),
    .imm        (instr[PC_W-1:0]),
    .jump       (jump),
    .branch     (branch),
    .branch_flip(branch_flip),
    .alu_zero   (alu_zero),
    .taken      (taken),
    .next_pc    (next_pc)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign opcode         = instr_valid ? instr[INSTR_W-1 -: 6] : OP_NOP;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus request/issue strobes.
  always_comb begin
    state_next  = state;
    req         = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          fetch_done = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          state_next = run ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction capture, PC update, redirect pulse and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= INSTR_W'(NOP_INSTR);
      redirect <= 1'b0;
      retired  <= '0;
    end else begin
      redirect <= retire & (jump | taken);
      if (fetch_done) begin
        instr <= imem.imem_rdata;
      end
      if (retire) begin
        pc      <= next_pc;
        retired <= retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses and redirect
// pulses are queued as each instruction retires and checked when the DUT responds.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, stall, jump, branch, branch_flip, alu_zero;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid, redirect;
  logic [7:0]  pc;
  logic [15:0] retired;

  fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) imem ();

  fetch_sequencer #(
    .PC_W    (8),
    .INSTR_W (32),
    .RESET_PC(8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem       (imem),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .stall      (stall),
    .jump       (jump),
    .branch     (branch),
    .branch_flip(branch_flip),
    .alu_zero   (alu_zero),
    .pc         (pc),
    .redirect   (redirect),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  addr_q[$];
  logic        redir_q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction from fetch request to retirement, with optional memory
  // wait cycles, stall cycles and run dropped while the fetch is outstanding.
  task automatic run_instr(input logic [31:0] word, input logic j, input logic b,
                           input logic f, input logic z, input int unsigned ack_dly,
                           input int unsigned stall_cyc, input logic drop_run);
    int unsigned n;
    logic [7:0]  exp_addr, nxt;
    logic        tk, exp_redir;
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", imem.imem_req, 1'b1);
    check("addr_q_depth", addr_q.size(), 1);
    exp_addr = (addr_q.size() != 0) ? addr_q.pop_front() : 8'h00;
    check("fetch_addr", imem.imem_addr, exp_addr);
    if (drop_run) run = 1'b0;
    for (int unsigned i = 0; i < ack_dly; i++) begin
      tick();
      #1;
      check("addr_hold", imem.imem_addr, exp_addr);
      check("req_hold", imem.imem_req, 1'b1);
    end
    imem.imem_rdata = word;
    imem.imem_ack   = 1'b1;
    tick();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    jump = j; branch = b; branch_flip = f; alu_zero = z;
    stall = (stall_cyc != 0);
    #1;
    check("issue_valid", instr_valid, 1'b1);
    check("issue_req", imem.imem_req, 1'b0);
    check("instr", instr, word);
    check("opcode", opcode, word[31:26]);
    check("redirect_quiet", redirect, 1'b0);
    check("issue_pc", pc, m_pc);
    for (int unsigned i = 0; i < stall_cyc; i++) begin
      tick();
      if (i == stall_cyc - 1) stall = 1'b0;
      #1;
      check("stall_valid", instr_valid, 1'b1);
      check("stall_retired", retired, m_ret);
      check("stall_pc", pc, m_pc);
      check("stall_redirect", redirect, 1'b0);
    end
    tk = b & (z ^ f);
    if (j)       nxt = word[7:0];
    else if (tk) nxt = m_pc + 8'd1 + word[7:0];
    else         nxt = m_pc + 8'd1;
    redir_q.push_back(j | tk);
    if (run) addr_q.push_back(nxt);
    m_pc  = nxt;
    m_ret = m_ret + 16'd1;
    tick();
    jump = 1'b0; branch = 1'b0; branch_flip = 1'b0; alu_zero = 1'b0;
    #1;
    exp_redir = redir_q.pop_front();
    check("redirect", redirect, exp_redir);
    check("retired", retired, m_ret);
    check("valid_drop", instr_valid, 1'b0);
    check("opcode_nop", opcode, OP_NOP);
    check("next_pc", pc, m_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addi;
    addi = {OP_ADDI, 5'd1, 5'd2, 16'h0005};
    rst = 1'b1; run = 1'b0; stall = 1'b0;
    jump = 1'b0; branch = 1'b0; branch_flip = 1'b0; alu_zero = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_opcode", opcode, OP_NOP);
    check("rst_req", imem.imem_req, 1'b0);
    check("rst_redirect", redirect, 1'b0);
    check("rst_retired", retired, 16'd0);

    rst = 1'b0;
    m_pc = 8'h00; m_ret = 16'd0;
    addr_q.push_back(8'h00);
    run = 1'b1;
    for (int unsigned k = 0; k < 4; k++) run_instr(addi, 0, 0, 0, 0, 0, 0, 0);
    check("retired_4", retired, 16'd4);
    run_instr(addi, 0, 0, 0, 0, 0, 0, 0);                                 // pc 4 -> 5
    run_instr({OP_BEQ, 5'd1, 5'd2, 16'h0003}, 0, 1, 0, 1, 0, 0, 0);      // taken -> 9
    run_instr({OP_J, 26'h0000005}, 1, 0, 0, 0, 0, 0, 0);                 // -> 5
    run_instr({OP_BEQ, 5'd1, 5'd2, 16'h0003}, 0, 1, 0, 0, 0, 0, 0);      // not taken -> 6
    run_instr({OP_J, 26'h00000FA}, 1, 0, 0, 0, 1, 0, 0);                 // -> 250
    run_instr({OP_BNE, 5'd3, 5'd4, 16'h010A}, 0, 1, 1, 0, 0, 0, 0);      // -> 5 (wrap)
    run_instr({OP_J, 26'h0000040}, 1, 1, 0, 1, 0, 0, 0);                 // jump beats branch
    run_instr({OP_J, 26'h00000FF}, 1, 0, 0, 0, 0, 0, 0);                 // -> 255
    run_instr(addi, 0, 0, 0, 0, 3, 2, 0);                                 // 255 -> 0
    run_instr(addi, 0, 0, 0, 0, 2, 0, 1);                                 // run drops mid-fetch
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("idle_req", imem.imem_req, 1'b0);
      check("idle_pc", pc, m_pc);
    end

    // Restart, then reset in the middle of a fetch with a late ack afterwards.
    run = 1'b1;
    addr_q.push_back(m_pc);
    begin
      int unsigned n;
      n = 0;
      while (imem.imem_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("req_restart", imem.imem_req, 1'b1);
      check("addr_restart", imem.imem_addr, addr_q.pop_front());
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", imem.imem_req, 1'b0);
    check("arst_pc", pc, 8'h00);
    check("arst_retired", retired, 16'd0);
    run = 1'b0;
    tick();
    rst = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = addi;
    tick();
    imem.imem_ack = 1'b0;
    #1;
    check("late_ack_instr", instr, NOP_INSTR);
    check("late_ack_valid", instr_valid, 1'b0);
    check("late_ack_opcode", opcode, OP_NOP);
    check("late_ack_pc", pc, 8'h00);
    check("late_ack_retired", retired, 16'd0);
    repeat (2) begin
      tick();
      check("post_idle_req", imem.imem_req, 1'b0);
      check("post_idle_valid", instr_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
